inst_fetcher: RTL and testbench

Instruction fetch stage directly downstream of the memory controller / I-cache path. It holds the architectural fetch PC and requests instructions one at a time via the `_InstFetcher_need_inst` / `_inst_ready_in_Mem2Fetcher` handshake. It computes the next PC: JAL targets, sequential PC, and, optionally, static backward-taken branch prediction. Fetched instructions are buffered in a small queue feeding the decoder. On JALR it stops fetching and pulses `_stall_set` until the ROB resolves the target; `_clear` redirects fetch on misprediction.

---
 rtl/inst_fetcher_pkg.sv | 36 +++
 rtl/inst_fetcher_fetch_queue.sv | 78 +++++++
 rtl/inst_fetcher.sv | 182 ++++++++++++++++++
 tb/tb_inst_fetcher.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// =============================================================================
// Module   : inst_fetcher_pkg
// Brief    : Opcode constants, fetch state encoding and immediate decoders
//            shared by the instruction fetch stage.
// Revision : 1.0 - initial release
// =============================================================================
package inst_fetcher_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int ENTRY_W = 65;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        STALL = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetcher_fetch_queue.sv
`default_nettype none
// =============================================================================
// Module   : inst_fetcher_fetch_queue
// Brief    : Synchronous FIFO of fetched {pred, pc, inst} entries with
//            combinational head read and single-cycle flush.
// Revision : 1.0 - initial release
// =============================================================================
module inst_fetcher_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     i_en,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] count_t;
    localparam count_t FULL_COUNT = count_t'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    count_t           r_count;

    logic w_do_push;
    logic w_do_pop;

    // Flush dominates: a same-cycle push or pop is dropped.
    assign w_do_push = i_en && i_push && !i_flush && (r_count != FULL_COUNT);
    assign w_do_pop  = i_en && i_pop  && !i_flush && (r_count != '0);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_en && i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// =============================================================================
// Module   : inst_fetcher
// Brief    : Fetch PC, memory request handshake, next-PC selection and
//            decoder-facing instruction queue. FETCH_PREDICT_EN enables static
//            backward-taken branch prediction.
// Revision : 1.0 - initial release
// =============================================================================
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        _InstFetcher_need_inst,
    output logic [31:0] _pc_Fetcher2Mem,
    output logic        _stall_set,
    input  logic        _inst_ready_in_Mem2Fetcher,
    input  logic [31:0] _inst_in_Mem2Fetcher,
    input  logic        _stall_recover,
    input  logic [31:0] _recover_pc,
    input  logic        _clear,
    input  logic [31:0] _clear_pc,
    output logic        _inst_valid,
    output logic [31:0] _inst_out,
    output logic [31:0] _inst_pc,
    output logic        _inst_pred_taken,
    input  logic        _decoder_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    typedef logic [CW-1:0] count_t;
    localparam count_t DEPTH_COUNT = count_t'(QUEUE_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_stall_pulse;
    logic         w_stall_pulse_nxt;

    logic         w_need;
    logic         w_accept;
    logic         w_pop;
    logic         w_flush;
    logic         w_empty;
    logic         w_full_unused;
    count_t       w_count;
    logic         w_pred;
    logic         w_is_jalr;
    logic [6:0]   w_opcode;
    logic [31:0]  w_target_pc;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_opcode = _inst_in_Mem2Fetcher[6:0];

    assign w_need   = (r_state == FETCH) && (w_count < DEPTH_COUNT);
    assign w_accept = rdy_in && _inst_ready_in_Mem2Fetcher && w_need && !_clear;
    assign w_pop    = rdy_in && !w_empty && _decoder_ready && !_clear;
    assign w_flush  = rdy_in && _clear;

`ifdef FETCH_PREDICT_EN
    // Backward branches (negative immediate) are assumed to be loop closers.
    assign w_pred = (w_opcode == OP_BRANCH) && _inst_in_Mem2Fetcher[31];
`else
    assign w_pred = 1'b0;
`endif

    always_comb begin
        w_target_pc = r_pc + 32'd4;
        w_is_jalr   = 1'b0;
        case (w_opcode)
            OP_JAL: begin
                w_target_pc = r_pc + j_imm(_inst_in_Mem2Fetcher);
            end
            OP_JALR: begin
                w_target_pc = r_pc;
                w_is_jalr   = 1'b1;
            end
            OP_BRANCH: begin
                if (w_pred) begin
                    w_target_pc = r_pc + b_imm(_inst_in_Mem2Fetcher);
                end
            end
            default: begin
                w_target_pc = r_pc + 32'd4;
            end
        endcase
    end

    // Next-state logic; with rdy_in low everything, including a pending
    // stall pulse, holds.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_stall_pulse_nxt = r_stall_pulse;
        if (rdy_in) begin
            w_stall_pulse_nxt = 1'b0;
            if (_clear) begin
                w_state_nxt = FETCH;
                w_pc_nxt    = _clear_pc;
            end else begin
                case (r_state)
                    FETCH: begin
                        if (w_accept) begin
                            w_pc_nxt = w_target_pc;
                            if (w_is_jalr) begin
                                w_state_nxt       = STALL;
                                w_stall_pulse_nxt = 1'b1;
                            end
                        end
                    end
                    STALL: begin
                        if (_stall_recover) begin
                            w_state_nxt = FETCH;
                            w_pc_nxt    = _recover_pc;
                        end
                    end
                    default: begin
                        w_state_nxt = FETCH;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_stall_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_stall_pulse <= w_stall_pulse_nxt;
        end
    end

    assign w_push_entry.pred = w_pred;
    assign w_push_entry.pc   = r_pc;
    assign w_push_entry.inst = _inst_in_Mem2Fetcher;

    inst_fetcher_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_queue (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (rdy_in),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_full_unused),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign _InstFetcher_need_inst = w_need;
    assign _pc_Fetcher2Mem        = r_pc;
    assign _stall_set             = r_stall_pulse;
    assign _inst_valid            = !w_empty;
    assign _inst_out              = w_head.inst;
    assign _inst_pc               = w_head.pc;

`ifdef FETCH_PREDICT_EN
    // Storage is not reset, so mask the pred bit while the queue is empty.
    assign _inst_pred_taken = !w_empty && w_head.pred;
`else
    logic w_pred_unused;
    assign w_pred_unused    = w_head.pred;
    assign _inst_pred_taken = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// =============================================================================
// Module   : tb_inst_fetcher
// Brief    : Self-checking bench: directed decode table, corner sequences and a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_inst_fetcher;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] ADDI   = 32'h00100093;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        need, stall_set, mem_rdy, stall_recover, clear;
    logic        valid, pred, dec_rdy;
    logic [31:0] pc_req, mem_inst, recover_pc, clear_pc, head_inst, head_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    inst_fetcher #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        ._InstFetcher_need_inst     (need),
        ._pc_Fetcher2Mem            (pc_req),
        ._stall_set                 (stall_set),
        ._inst_ready_in_Mem2Fetcher (mem_rdy),
        ._inst_in_Mem2Fetcher       (mem_inst),
        ._stall_recover             (stall_recover),
        ._recover_pc                (recover_pc),
        ._clear                     (clear),
        ._clear_pc                  (clear_pc),
        ._inst_valid                (valid),
        ._inst_out                  (head_inst),
        ._inst_pc                   (head_pc),
        ._inst_pred_taken           (pred),
        ._decoder_ready             (dec_rdy)
    );

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] inst;
        logic [31:0] exp_next;
        logic        exp_pred;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    vec_t        vecs[7];
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_stall, m_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        mem_rdy       = 1'b0;
        mem_inst      = 32'h0;
        stall_recover = 1'b0;
        recover_pc    = 32'h0;
        clear         = 1'b0;
        clear_pc      = 32'h0;
        dec_rdy       = 1'b0;
    endtask

    // Next fetch PC from the instruction's field arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                             output logic p);
        int          off;
        logic [31:0] nxt;
        p   = 1'b0;
        nxt = pc + 32'd4;
        if (inst[6:0] == 7'h6F) begin
            off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048
                + int'(inst[19:12]) * 4096 - int'(inst[31]) * 1048576;
            nxt = pc + 32'(off);
        end else if (inst[6:0] == 7'h67) begin
            nxt = pc;
        end else if (inst[6:0] == 7'h63) begin
`ifdef FETCH_PREDICT_EN
            if (inst[31]) begin
                off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32
                    + int'(inst[7]) * 2048 - 4096;
                nxt = pc + 32'(off);
                p   = 1'b1;
            end
`endif
        end
        return nxt;
    endfunction

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h0200_00EF, 32'h0000_0030, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'hFFDF_F06F, 32'h0000_00FC, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, ADDI,          32'h0000_0000, 1'b0};
`ifdef FETCH_PREDICT_EN
        vecs[3] = '{32'h0000_0020, 32'hFE00_0CE3, 32'h0000_0018, 1'b1};
`else
        vecs[3] = '{32'h0000_0020, 32'hFE00_0CE3, 32'h0000_0024, 1'b0};
`endif
        vecs[4] = '{32'h0000_0040, 32'h0000_0863, 32'h0000_0044, 1'b0};
        vecs[5] = '{32'h0000_0080, 32'h0010_006F, 32'h0000_0880, 1'b0};
        vecs[6] = '{32'h0000_1000, 32'h0000_106F, 32'h0000_2000, 1'b0};

        // Reset
        idle();
        rst_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
        step();
        chk("rst_need", need, 1);
        chk("rst_pc", pc_req, RST_PC);
        chk("rst_valid", valid, 0);
        chk("rst_stall_set", stall_set, 0);
        chk("rst_pred", pred, 0);

        // Three sequential ADDIs, decoder always ready
        dec_rdy  = 1'b1;
        mem_rdy  = 1'b1;
        mem_inst = ADDI;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_req_pc", pc_req, 32'(4 * (i + 1)));
            chk("seq_valid", valid, 1);
            chk("seq_head_pc", head_pc, 32'(4 * i));
            chk("seq_stall_set", stall_set, 0);
        end
        mem_rdy = 1'b0;
        step();
        chk("seq_drained", valid, 0);

        // Next-PC decode table
        for (int v = 0; v < 7; v++) begin
            idle();
            dec_rdy  = 1'b1;
            clear    = 1'b1;
            clear_pc = vecs[v].start_pc;
            step();
            clear = 1'b0;
            chk("tbl_start_pc", pc_req, vecs[v].start_pc);
            mem_rdy  = 1'b1;
            mem_inst = vecs[v].inst;
            step();
            mem_rdy = 1'b0;
            chk("tbl_next_pc", pc_req, vecs[v].exp_next);
            chk("tbl_head_pc", head_pc, vecs[v].start_pc);
            chk("tbl_head_inst", head_inst, vecs[v].inst);
            chk("tbl_pred", pred, vecs[v].exp_pred);
        end

        // JALR stall and recover
        idle();
        dec_rdy  = 1'b1;
        clear    = 1'b1;
        clear_pc = 32'h8;
        step();
        clear    = 1'b0;
        mem_rdy  = 1'b1;
        mem_inst = 32'h0000_80E7;
        step();
        chk("jalr_stall_set", stall_set, 1);
        chk("jalr_need_low", need, 0);
        chk("jalr_head_pc", head_pc, 32'h8);
        mem_inst = ADDI;
        step();
        chk("jalr_pulse_once", stall_set, 0);
        chk("jalr_need_still_low", need, 0);
        chk("jalr_no_enqueue", valid, 0);
        mem_rdy       = 1'b0;
        stall_recover = 1'b1;
        recover_pc    = 32'h100;
        step();
        stall_recover = 1'b0;
        chk("recover_need", need, 1);
        chk("recover_pc", pc_req, 32'h100);

        // Second JALR, then clear and recover together: clear wins
        mem_rdy  = 1'b1;
        mem_inst = 32'h0000_80E7;
        step();
        mem_rdy       = 1'b0;
        clear         = 1'b1;
        clear_pc      = 32'h300;
        stall_recover = 1'b1;
        recover_pc    = 32'h500;
        step();
        clear         = 1'b0;
        stall_recover = 1'b0;
        chk("clr_vs_rec_pc", pc_req, 32'h300);
        chk("clr_vs_rec_need", need, 1);

        // Full queue with the decoder stalled
        idle();
        clear    = 1'b1;
        clear_pc = 32'h200;
        step();
        clear    = 1'b0;
        mem_rdy  = 1'b1;
        mem_inst = ADDI;
        for (int i = 0; i < 4; i++) step();
        chk("full_need_low", need, 0);
        chk("full_req_pc", pc_req, 32'h210);
        dec_rdy = 1'b1;
        step();
        dec_rdy = 1'b0;
        chk("full_need_back", need, 1);
        chk("full_head_after_pop", head_pc, 32'h204);
        step();
        chk("full_refilled", need, 0);
        mem_rdy = 1'b0;
        dec_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_drain_pc", head_pc, 32'h204 + 32'(4 * i));
            step();
        end
        chk("full_drain_empty", valid, 0);

        // Clear in the same cycle as a ready word and a dequeue
        dec_rdy  = 1'b0;
        mem_rdy  = 1'b1;
        mem_inst = ADDI;
        step();
        step();
        dec_rdy  = 1'b1;
        mem_inst = 32'hABCD_E013;
        clear    = 1'b1;
        clear_pc = 32'h40;
        step();
        clear    = 1'b0;
        mem_inst = 32'h0000_0013;
        chk("clr_valid", valid, 0);
        chk("clr_need", need, 1);
        chk("clr_pc", pc_req, 32'h40);
        dec_rdy = 1'b0;
        step();
        mem_rdy = 1'b0;
        chk("clr_head_inst", head_inst, 32'h0000_0013);
        chk("clr_head_pc", head_pc, 32'h40);

        // Randomized run against the reference model
        idle();
        rst_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
        m_q.delete();
        m_pc    = RST_PC;
        m_stall = 1'b0;
        m_pulse = 1'b0;
        step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        m_need, acc, deq, jalr_acc, p;
            logic [31:0] nxt;
            int          kind;
            m_need = !m_stall && (m_q.size() < DEPTH);
            chk("rnd_need", need, m_need);
            chk("rnd_pc", pc_req, m_pc);
            chk("rnd_stall_set", stall_set, m_pulse);
            chk("rnd_valid", valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("rnd_head_inst", head_inst, m_q[0].inst);
                chk("rnd_head_pc", head_pc, m_q[0].pc);
                chk("rnd_head_pred", pred, m_q[0].pred);
            end else begin
                chk("rnd_pred_empty", pred, 0);
            end

            rdy_in        = ($urandom_range(0, 9) != 0);
            mem_rdy       = ($urandom_range(0, 9) < 6);
            dec_rdy       = ($urandom_range(0, 9) < 5);
            clear         = ($urandom_range(0, 39) == 0);
            clear_pc      = $urandom();
            stall_recover = ($urandom_range(0, 4) == 0);
            recover_pc    = $urandom();
            kind          = $urandom_range(0, 9);
            mem_inst      = $urandom();
            if (kind < 5)      mem_inst[6:0] = 7'h13;
            else if (kind < 7) mem_inst[6:0] = 7'h6F;
            else if (kind < 9) mem_inst[6:0] = 7'h63;
            else               mem_inst[6:0] = 7'h67;

            if (rdy_in) begin
                jalr_acc = 1'b0;
                if (clear) begin
                    m_q.delete();
                    m_pc    = clear_pc;
                    m_stall = 1'b0;
                end else begin
                    acc = m_need && mem_rdy;
                    deq = (m_q.size() > 0) && dec_rdy;
                    if (deq) void'(m_q.pop_front());
                    if (m_stall) begin
                        if (stall_recover) begin
                            m_pc    = recover_pc;
                            m_stall = 1'b0;
                        end
                    end else if (acc) begin
                        nxt = ref_next(m_pc, mem_inst, p);
                        m_q.push_back('{inst: mem_inst, pc: m_pc, pred: p});
                        m_pc = nxt;
                        if (mem_inst[6:0] == 7'h67) begin
                            m_stall  = 1'b1;
                            jalr_acc = 1'b1;
                        end
                    end
                end
                m_pulse = jalr_acc;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
